// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions: opcode constants, instruction field positions and
// the memory-access state encoding used by the memory-stage controller.
package mem_access_unit_pkg;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 27;

   localparam logic [4:0] OP_LW = 5'b01000;
   localparam logic [4:0] OP_SW = 5'b00111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } mau_state_e;

   function automatic logic [4:0] opcode_of(input logic [31:0] instruction);
      return instruction[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for the data-memory handshake; expired flags the
// last permitted wait cycle so the controller can abandon the access.
module mem_wait_timer #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             enable,
   output logic             expired
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = {CNT_W{1'b1}};

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != MAX_CNT)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (count >= LAST_CNT);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage data-memory port controller: issues one req/ack access per lw/sw,
// stalls the pipeline until it completes, and loads the memory/writeback register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight; non-memory ops pass straight to W
// WAIT    | dmem_req high, waiting for dmem_ack or the timeout
// DONE    | access finished; held instruction retires into W once
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        m_valid,
   input  logic [31:0] m_instruction,
   input  logic [31:0] m_address,
   input  logic [31:0] m_store_data,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        w_valid,
   output logic [31:0] w_instruction,
   output logic [31:0] w_data,
   output logic        mem_error
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   mau_state_e  state_q, state_d;
   logic [31:0] load_buf;
   logic        is_lw, is_sw, mem_op;
   logic        timer_clear, timer_en, timer_expired;

   assign is_lw  = (opcode_of(m_instruction) == OP_LW);
   assign is_sw  = (opcode_of(m_instruction) == OP_SW);
   assign mem_op = m_valid && (is_lw || is_sw);

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_wait_timer (
      .clock      (clock),
      .reset      (reset),
      .clear      (timer_clear),
      .load       (1'b0),
      .load_value ({CNT_W{1'b0}}),
      .enable     (timer_en),
      .expired    (timer_expired)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      stall       = 1'b0;
      timer_clear = 1'b0;
      timer_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_op) begin
               stall       = 1'b1;
               timer_clear = 1'b1;
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            stall    = 1'b1;
            timer_en = 1'b1;
            if (dmem_ack || timer_expired) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath registers; ack wins over the timeout when both land together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         load_buf      <= '0;
         w_valid       <= 1'b0;
         w_instruction <= '0;
         w_data        <= '0;
         mem_error     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mem_op) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= is_sw;
                  dmem_addr  <= m_address;
                  dmem_wdata <= m_store_data;
                  w_valid    <= 1'b0;
               end else begin
                  w_valid       <= m_valid;
                  w_instruction <= m_instruction;
                  w_data        <= m_address;
               end
            end
            ST_WAIT: begin
               w_valid <= 1'b0;
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  load_buf <= dmem_rdata;
               end else if (timer_expired) begin
                  dmem_req  <= 1'b0;
                  load_buf  <= '0;
                  mem_error <= 1'b1;
               end
            end
            ST_DONE: begin
               w_valid       <= 1'b1;
               w_instruction <= m_instruction;
               w_data        <= is_lw ? load_buf : m_address;
            end
            default: begin
               dmem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// instruction streams checked against a transaction-level reference model.
module tb_mem_access_unit;

   localparam int         TB_TIMEOUT = 16;
   localparam logic [4:0] TB_LW      = 5'b01000;
   localparam logic [4:0] TB_SW      = 5'b00111;
   localparam logic [4:0] TB_ADD     = 5'b00000;
   localparam int         NO_ACK     = 99;

   logic        clock = 1'b0;
   logic        reset;
   logic        m_valid;
   logic [31:0] m_instruction;
   logic [31:0] m_address;
   logic [31:0] m_store_data;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        w_valid;
   logic [31:0] w_instruction;
   logic [31:0] w_data;
   logic        mem_error;

   int n_checks = 0;
   int n_fail   = 0;
   logic err_exp = 1'b0;

   mem_access_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clock         (clock),
      .reset         (reset),
      .m_valid       (m_valid),
      .m_instruction (m_instruction),
      .m_address     (m_address),
      .m_store_data  (m_store_data),
      .stall         (stall),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_ack      (dmem_ack),
      .dmem_rdata    (dmem_rdata),
      .w_valid       (w_valid),
      .w_instruction (w_instruction),
      .w_data        (w_data),
      .mem_error     (mem_error)
   );

   always #5 clock = ~clock;

   // Transaction-level model: one instruction in, its stall/request cost and W result out.
   task automatic model_op(input logic [31:0] instr, input logic valid, input logic [31:0] addr,
                           input int delay, input logic [31:0] rdata,
                           output int e_stall, output int e_req, output logic e_wv,
                           output logic [31:0] e_wd);
      logic is_mem, is_sw, tmo;
      is_mem  = valid && (instr[31:27] == TB_LW || instr[31:27] == TB_SW);
      is_sw   = (instr[31:27] == TB_SW);
      tmo     = is_mem && (delay >= TB_TIMEOUT);
      e_stall = !is_mem ? 0 : (tmo ? TB_TIMEOUT + 1 : delay + 2);
      e_req   = !is_mem ? 0 : (tmo ? TB_TIMEOUT : delay + 1);
      e_wv    = is_mem ? 1'b1 : valid;
      e_wd    = (!is_mem || is_sw) ? addr : (tmo ? 32'd0 : rdata);
      if (tmo) err_exp = 1'b1;
   endtask

   // Drives one instruction, plays the memory side and reports what was observed.
   task automatic drive_op(input logic [31:0] instr, input logic valid, input logic [31:0] addr,
                           input logic [31:0] sdata, input int delay, input logic [31:0] rdata,
                           input logic spurious,
                           output int n_stall, output int n_req, output int n_unstable,
                           output logic o_wv, output logic [31:0] o_wi, output logic [31:0] o_wd,
                           output logic o_err, output logic o_req);
      int cyc;
      logic exp_we;
      exp_we        = (instr[31:27] == TB_SW);
      m_valid       = valid;
      m_instruction = instr;
      m_address     = addr;
      m_store_data  = sdata;
      dmem_ack      = 1'b0;
      n_stall       = 0;
      n_req         = 0;
      n_unstable    = 0;
      cyc           = 0;
      #1;
      while (stall === 1'b1 && cyc < 100) begin
         n_stall++;
         if (dmem_req === 1'b1) begin
            if (dmem_addr !== addr || dmem_wdata !== sdata || dmem_we !== exp_we) n_unstable++;
            dmem_ack   = (n_req == delay) ? 1'b1 : 1'b0;
            dmem_rdata = dmem_ack ? rdata : $urandom;
            n_req++;
         end else begin
            dmem_ack = 1'b0;
         end
         @(negedge clock);
         #1;
         cyc++;
      end
      if (cyc >= 100) n_stall = -1;
      dmem_ack   = spurious;
      dmem_rdata = $urandom;
      @(negedge clock);
      dmem_ack = 1'b0;
      #1;
      o_wv  = w_valid;
      o_wi  = w_instruction;
      o_wd  = w_data;
      o_err = mem_error;
      o_req = dmem_req;
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      m_valid       = 1'b0;
      m_instruction = '0;
      m_address     = '0;
      m_store_data  = '0;
      dmem_ack      = 1'b0;
      dmem_rdata    = '0;
      repeat (3) @(negedge clock);
      #1;
      n_checks++;
      if ({dmem_req, dmem_we, w_valid, mem_error, stall} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got req/we/wv/err/stall=%b expected 00000",
                  {dmem_req, dmem_we, w_valid, mem_error, stall});
      end
      n_checks++;
      if ({dmem_addr, dmem_wdata, w_instruction, w_data} !== 128'd0) begin
         n_fail++;
         $display("FAIL reset_words: addr=%h wdata=%h wi=%h wd=%h expected all zero",
                  dmem_addr, dmem_wdata, w_instruction, w_data);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_non_mem();
      int ns, nr, nu;
      logic wv, er, rq;
      logic [31:0] wi, wd, instr;
      instr = {TB_ADD, 27'h0123456};
      drive_op(instr, 1'b1, 32'h0000_0005, 32'hFFFF_0000, 0, 32'd0, 1'b0,
               ns, nr, nu, wv, wi, wd, er, rq);
      n_checks++;
      if (ns !== 0) begin n_fail++; $display("FAIL add_stall: got %0d cycles expected 0", ns); end
      n_checks++;
      if (wv !== 1'b1 || wd !== 32'd5 || wi !== instr) begin
         n_fail++;
         $display("FAIL add_w: got v=%b i=%h d=%h expected v=1 i=%h d=5", wv, wi, wd, instr);
      end
   endtask

   task automatic test_load();
      int ns, nr, nu;
      logic wv, er, rq;
      logic [31:0] wi, wd, instr;
      instr = {TB_LW, 27'h0000010};
      drive_op(instr, 1'b1, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 1'b0,
               ns, nr, nu, wv, wi, wd, er, rq);
      n_checks++;
      if (ns !== 3) begin n_fail++; $display("FAIL lw_stall: got %0d expected 3", ns); end
      n_checks++;
      if (nr !== 2 || nu !== 0) begin
         n_fail++;
         $display("FAIL lw_req: got %0d req cycles, %0d unstable expected 2, 0", nr, nu);
      end
      n_checks++;
      if (wv !== 1'b1 || wd !== 32'hDEAD_BEEF || wi !== instr || rq !== 1'b0) begin
         n_fail++;
         $display("FAIL lw_w: got v=%b d=%h i=%h req=%b expected v=1 d=deadbeef i=%h req=0",
                  wv, wd, wi, rq, instr);
      end
   endtask

   task automatic test_store();
      int ns, nr, nu;
      logic wv, er, rq;
      logic [31:0] wi, wd, instr;
      instr = {TB_SW, 27'h0000020};
      drive_op(instr, 1'b1, 32'h20, 32'h1234, 4, 32'hBAD0_BAD0, 1'b0,
               ns, nr, nu, wv, wi, wd, er, rq);
      n_checks++;
      if (ns !== 6) begin n_fail++; $display("FAIL sw_stall: got %0d expected 6", ns); end
      n_checks++;
      if (nr !== 5 || nu !== 0) begin
         n_fail++;
         $display("FAIL sw_req: got %0d req cycles, %0d unstable expected 5, 0", nr, nu);
      end
      n_checks++;
      if (wv !== 1'b1 || wd !== 32'h20 || rq !== 1'b0 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL sw_w: got v=%b d=%h req=%b err=%b expected v=1 d=20 req=0 err=0",
                  wv, wd, rq, er);
      end
   endtask

   task automatic test_spurious_ack();
      int ns, nr, nu;
      logic wv, er, rq;
      logic [31:0] wi, wd;
      drive_op({TB_ADD, 27'h7}, 1'b1, 32'h77, 32'h0, 0, 32'd0, 1'b1,
               ns, nr, nu, wv, wi, wd, er, rq);
      n_checks++;
      if (ns !== 0 || rq !== 1'b0 || wd !== 32'h77) begin
         n_fail++;
         $display("FAIL idle_spurious: got stall=%0d req=%b d=%h expected 0 0 77", ns, rq, wd);
      end
      drive_op({TB_LW, 27'h40}, 1'b1, 32'h40, 32'h0, 0, 32'hCAFE_F00D, 1'b1,
               ns, nr, nu, wv, wi, wd, er, rq);
      n_checks++;
      if (ns !== 2 || nr !== 1 || wd !== 32'hCAFE_F00D || rq !== 1'b0) begin
         n_fail++;
         $display("FAIL done_spurious: got stall=%0d req=%0d d=%h rq=%b expected 2 1 cafef00d 0",
                  ns, nr, wd, rq);
      end
      drive_op({TB_ADD, 27'h8}, 1'b1, 32'h88, 32'h0, 0, 32'd0, 1'b0,
               ns, nr, nu, wv, wi, wd, er, rq);
      n_checks++;
      if (ns !== 0 || wd !== 32'h88 || wv !== 1'b1) begin
         n_fail++;
         $display("FAIL after_spurious: got stall=%0d d=%h v=%b expected 0 88 1", ns, wd, wv);
      end
   endtask

   task automatic test_back_to_back();
      int ns, nr, nu;
      logic wv, er, rq;
      logic [31:0] wi, wd;
      drive_op({TB_LW, 27'h100}, 1'b1, 32'h100, 32'h0, 0, 32'h1111_1111, 1'b0,
               ns, nr, nu, wv, wi, wd, er, rq);
      n_checks++;
      if (nr !== 1 || wd !== 32'h1111_1111 || wv !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first: got req=%0d d=%h v=%b expected 1 11111111 1", nr, wd, wv);
      end
      drive_op({TB_LW, 27'h104}, 1'b1, 32'h104, 32'h0, 2, 32'h2222_2222, 1'b0,
               ns, nr, nu, wv, wi, wd, er, rq);
      n_checks++;
      if (nr !== 3 || ns !== 4 || nu !== 0 || wd !== 32'h2222_2222) begin
         n_fail++;
         $display("FAIL b2b_second: got req=%0d stall=%0d unst=%0d d=%h expected 3 4 0 22222222",
                  nr, ns, nu, wd);
      end
   endtask

   task automatic test_random();
      int ns, nr, nu, e_ns, e_nr, delay;
      logic wv, er, rq, e_wv, valid;
      logic [31:0] wi, wd, e_wd, instr, rnd, addr, sdata, rdata;
      logic [4:0] op;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: op = TB_LW;
            1: op = TB_SW;
            2: op = 5'($urandom_range(0, 31));
            default: op = TB_ADD;
         endcase
         rnd   = $urandom;
         instr = {op, rnd[26:0]};
         valid = ($urandom_range(0, 7) != 0);
         addr  = $urandom;
         sdata = $urandom;
         rdata = $urandom;
         delay = ($urandom_range(0, 9) == 0) ? TB_TIMEOUT - 1 : $urandom_range(0, 5);
         model_op(instr, valid, addr, delay, rdata, e_ns, e_nr, e_wv, e_wd);
         drive_op(instr, valid, addr, sdata, delay, rdata, ($urandom_range(0, 3) == 0),
                  ns, nr, nu, wv, wi, wd, er, rq);
         n_checks++;
         if (ns !== e_ns || nr !== e_nr || nu !== 0) begin
            n_fail++;
            $display("FAIL rand_timing[%0d]: got stall=%0d req=%0d unst=%0d expected %0d %0d 0",
                     i, ns, nr, nu, e_ns, e_nr);
         end
         n_checks++;
         if (wv !== e_wv || wd !== e_wd || wi !== instr || rq !== 1'b0 || er !== err_exp) begin
            n_fail++;
            $display("FAIL rand_w[%0d]: got v=%b d=%h i=%h req=%b err=%b expected %b %h %h 0 %b",
                     i, wv, wd, wi, rq, er, e_wv, e_wd, instr, err_exp);
         end
      end
   endtask

   task automatic test_timeout();
      int ns, nr, nu;
      logic wv, er, rq;
      logic [31:0] wi, wd;
      drive_op({TB_LW, 27'h300}, 1'b1, 32'h300, 32'h0, TB_TIMEOUT - 1, 32'h5A5A_5A5A, 1'b0,
               ns, nr, nu, wv, wi, wd, er, rq);
      n_checks++;
      if (nr !== 16 || ns !== 17 || er !== 1'b0 || wd !== 32'h5A5A_5A5A) begin
         n_fail++;
         $display("FAIL late_ack: got req=%0d stall=%0d err=%b d=%h expected 16 17 0 5a5a5a5a",
                  nr, ns, er, wd);
      end
      drive_op({TB_LW, 27'h304}, 1'b1, 32'h304, 32'h0, NO_ACK, 32'd0, 1'b0,
               ns, nr, nu, wv, wi, wd, er, rq);
      n_checks++;
      if (nr !== 16 || ns !== 17 || nu !== 0) begin
         n_fail++;
         $display("FAIL timeout_len: got req=%0d stall=%0d unst=%0d expected 16 17 0", nr, ns, nu);
      end
      n_checks++;
      if (er !== 1'b1 || wd !== 32'd0 || wv !== 1'b1 || rq !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_w: got err=%b d=%h v=%b req=%b expected 1 0 1 0", er, wd, wv, rq);
      end
      drive_op({TB_ADD, 27'h9}, 1'b1, 32'h99, 32'h0, 0, 32'd0, 1'b0,
               ns, nr, nu, wv, wi, wd, er, rq);
      n_checks++;
      if (ns !== 0 || wd !== 32'h99 || er !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_resume: got stall=%0d d=%h err=%b expected 0 99 1", ns, wd, er);
      end
   endtask

   task automatic test_reset_mid_access();
      int cyc;
      m_valid       = 1'b1;
      m_instruction = {TB_SW, 27'h55};
      m_address     = 32'hA5A5_0000;
      m_store_data  = 32'h0F0F_0F0F;
      dmem_ack      = 1'b0;
      cyc           = 0;
      #1;
      while (dmem_req !== 1'b1 && cyc < 10) begin
         @(negedge clock);
         #1;
         cyc++;
      end
      @(negedge clock);
      #1;
      n_checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_req: got req=%b we=%b expected 1 1", dmem_req, dmem_we);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({dmem_req, dmem_we, w_valid, mem_error} !== 4'b0 ||
          {dmem_addr, dmem_wdata, w_instruction, w_data} !== 128'd0) begin
         n_fail++;
         $display("FAIL async_reset: got req=%b we=%b wv=%b err=%b addr=%h wdata=%h expected all 0",
                  dmem_req, dmem_we, w_valid, mem_error, dmem_addr, dmem_wdata);
      end
      n_checks++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_stall: got %b expected 1 (idle with sw present)", stall);
      end
      m_valid  = 1'b0;
      dmem_ack = 1'b1;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      dmem_ack = 1'b0;
      #1;
      n_checks++;
      if (dmem_req !== 1'b0 || stall !== 1'b0 || w_valid !== 1'b0 || mem_error !== 1'b0) begin
         n_fail++;
         $display("FAIL late_ack_ignored: got req=%b stall=%b wv=%b err=%b expected 0 0 0 0",
                  dmem_req, stall, w_valid, mem_error);
      end
      err_exp = 1'b0;
   endtask

   initial begin
      test_reset();
      test_non_mem();
      test_load();
      test_store();
      test_spurious_ack();
      test_back_to_back();
      test_random();
      test_timeout();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-memory port controller for the 5-stage pipeline. It sits downstream of the memory-stage bypass: it takes the memory-stage instruction, the ALU address and the already-bypassed store data, and drives a request/acknowledge handshake to a variable-latency data memory. It stalls the pipeline until the access completes and loads the memory/writeback register (instruction plus register data) consumed by writeback and by the bypass network.

## Interface
- `TIMEOUT`, 16, max cycles to wait for `dmem_ack` before abandoning an access
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `m_valid`  in  1  memory-stage slot holds a real instruction
- `m_instruction`  in  32  memory-stage instruction; opcode = [31:27]
- `m_address`  in  32  ALU result (address for lw/sw, result otherwise)
- `m_store_data`  in  32  bypassed rd value for sw
- `stall`  out  1  hold PC, F/D, D/X and X/M registers this cycle
- `dmem_req`  out  1  access request, registered
- `dmem_we`  out  1  1 = write (sw), 0 = read (lw); valid while `dmem_req`
- `dmem_addr`  out  32  latched access address
- `dmem_wdata`  out  32  latched store data
- `dmem_ack`  in  1  one-cycle completion pulse from memory
- `dmem_rdata`  in  32  load data, valid with `dmem_ack`
- `w_valid`  out  1  writeback register holds a real instruction
- `w_instruction`  out  32  writeback instruction
- `w_data`  out  32  writeback register data
- `mem_error`  out  1  sticky: an access timed out

## Operation
- Memory op: opcode `01000` (lw) or `00111` (sw), gated by `m_valid`.
- States: IDLE, WAIT, DONE.
- IDLE, memory op present: `stall`=1 (combinational); at the clock edge, latch `dmem_addr`←`m_address`, `dmem_wdata`←`m_store_data`, `dmem_we`←(sw); `dmem_req`←1; clear the wait counter; go to WAIT. W register loads a bubble (`w_valid`←0).
- IDLE, non-memory or invalid slot: `stall`=0; W register loads `m_valid`, `m_instruction` and `m_address`.
- WAIT: `stall`=1, `dmem_req` held at 1, address/data/we stable. The counter increments each cycle.
  - On `dmem_ack`: capture `dmem_rdata` into the load buffer, `dmem_req`←0, go to DONE.
  - If the counter reaches `TIMEOUT`-1 without an ack: `dmem_req`←0, load buffer←0, `mem_error`←1, go to DONE.
  - Ack takes priority over timeout in the same cycle.
- DONE: `stall`=0. W register loads `m_instruction` with `w_valid`=1. `w_data` = load buffer for lw, `m_address` for sw. Go to IDLE. The held instruction is consumed exactly once and never re-issued.
- `dmem_ack` outside WAIT is ignored.
- `mem_error` clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `w_valid`=0, `w_instruction`=0, `w_data`=0, `mem_error`=0, counter=0. `stall` derives from IDLE and the inputs.
- Reset mid-access drops `dmem_req` immediately. An in-flight ack after release is ignored because the unit is in IDLE.
- Non-memory instruction: W valid 1 edge after M.
- Memory op detected at edge-window T:
  - `dmem_req` high from edge T+1.
  - Earliest ack is in cycle T+1, giving DONE in cycle T+2 and W valid after edge T+3.
  - Total stall = 2 + (ack delay) cycles.
- Timeout: `dmem_req` high for exactly `TIMEOUT` cycles.
- The counter is $clog2(`TIMEOUT`)+1 bits and saturates; it never wraps.

## Structure
- Shared package: opcode constants (`OP_LW`=5'b01000, `OP_SW`=5'b00111), state encoding, instruction field positions. Other pipeline units (bypass, hazard) use the same package.
- One sub-module: `mem_wait_timer`. It is a loadable/clearable saturating counter with an `expired` output, parameterised by `TIMEOUT`.

## Test plan
- Reset asserted during WAIT with `dmem_req`=1 → all outputs drop to reset values asynchronously, with no clock edge needed.
- add, `m_address`=0x0000_0005, `m_valid`=1 → `stall`=0; next cycle `w_valid`=1, `w_data`=5.
- lw, address 0x10, memory acks 1 cycle after req with rdata 0xDEAD_BEEF → `stall` high 3 cycles; `dmem_we`=0, `dmem_addr`=0x10; after that, `w_data`=0xDEAD_BEEF.
- sw, address 0x20, store data 0x1234, ack after 4 cycles → `dmem_we`=1, `dmem_wdata`=0x1234 stable throughout; `stall` high 6 cycles; `w_data`=0x20; exactly one request.
- lw with no ack, `TIMEOUT`=16 → `dmem_req` high exactly 16 cycles; `mem_error`=1 and stays 1; `w_data`=0; the pipeline then resumes.
- Spurious `dmem_ack` in IDLE and DONE → no state change. Two back-to-back lw → two separate requests, each consumed once.
